// File: rtl/core_wb_pkg.sv
// Shared definitions for the core-side Wishbone data master.
// Holds the default parameter values and the FSM state type with its
// encodings:
//   IDLE  - nothing outstanding
//   BUSY  - one or more requests awaiting ack/err
//   ABORT - single cycle after a bus error or timeout, bus released
package core_wb_pkg;

  localparam int DEF_AW          = 32;
  localparam int DEF_DW          = 32;
  localparam int DEF_MAX_OUTST   = 4;
  localparam int DEF_TIMEOUT_CYC = 1024;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t BUSY  = 2'd1;
  localparam state_t ABORT = 2'd2;

endpackage

// File: rtl/core_wb_data_master_if.sv
// Bundle of the core request/response signals and the Wishbone B4
// pipelined master signals.
//   master modport : view of the data master (drives core_*_o, wb_*_o)
//   slave modport  : view of the surrounding core and bus slave
// Signal names keep their _i/_o suffixes relative to the data master.
interface core_wb_data_master_if
  import core_wb_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
);

  logic            core_req_i;
  logic            core_we_i;
  logic [AW-1:0]   core_adr_i;
  logic [DW-1:0]   core_dat_i;
  logic [DW/8-1:0] core_sel_i;
  logic            core_stall_o;
  logic            core_rvalid_o;
  logic [DW-1:0]   core_rdata_o;
  logic            core_err_o;

  logic            wb_cyc_o;
  logic            wb_stb_o;
  logic            wb_we_o;
  logic [AW-1:0]   wb_adr_o;
  logic [DW-1:0]   wb_dat_o;
  logic [DW/8-1:0] wb_sel_o;
  logic            wb_stall_i;
  logic            wb_ack_i;
  logic            wb_err_i;
  logic [DW-1:0]   wb_dat_i;

  modport master (
    input  core_req_i, core_we_i, core_adr_i, core_dat_i, core_sel_i,
    output core_stall_o, core_rvalid_o, core_rdata_o, core_err_o,
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
    input  wb_stall_i, wb_ack_i, wb_err_i, wb_dat_i
  );

  modport slave (
    output core_req_i, core_we_i, core_adr_i, core_dat_i, core_sel_i,
    input  core_stall_o, core_rvalid_o, core_rdata_o, core_err_o,
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
    output wb_stall_i, wb_ack_i, wb_err_i, wb_dat_i
  );

endinterface

// File: rtl/wb_timeout_ctr.sv
// Response timeout counter for the Wishbone data master.
//   clk, rst : clock and asynchronous active-high reset
//   run      : a response is being waited for this cycle
//   clear    : restart the count (has priority over run)
//   expired  : this waiting cycle is the TIMEOUT_CYC-th in a row
// TIMEOUT_CYC = 0 disables the counter; expired is then tied low.
module wb_timeout_ctr
  import core_wb_pkg::*;
#(
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear,
  output logic expired
);

  if (TIMEOUT_CYC == 0) begin : g_off
    assign expired = 1'b0;
  end else begin : g_on
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] cnt_r;

    // Count consecutive waiting cycles, saturating at TIMEOUT_CYC.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_r <= {TW{1'b0}};
      end else if (clear) begin
        cnt_r <= {TW{1'b0}};
      end else if (run && (cnt_r != TW'(TIMEOUT_CYC))) begin
        cnt_r <= cnt_r + TW'(1);
      end else begin
        cnt_r <= cnt_r;
      end
    end

    // The count holds the number of earlier waiting cycles, so the
    // TIMEOUT_CYC-th waiting cycle is the one that sees TIMEOUT_CYC-1.
    assign expired = run & (cnt_r == TW'(TIMEOUT_CYC - 1));
  end

endmodule

// File: rtl/core_wb_data_master.sv
// Core data-port to Wishbone B4 pipelined master bridge.
//   data_wb_clk_i : clock
//   data_wb_rst_i : asynchronous active-high reset
//   bus           : core request/response and Wishbone master signals
// Requests pass straight through to the bus; up to MAX_OUTST may be
// outstanding. Responses return with zero latency. A bus error or a
// response timeout pulses core_err_o, drops every outstanding request
// and releases the bus for one ABORT cycle.
module core_wb_data_master
  import core_wb_pkg::*;
#(
  parameter int AW          = DEF_AW,
  parameter int DW          = DEF_DW,
  parameter int MAX_OUTST   = DEF_MAX_OUTST,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                 data_wb_clk_i,
  input  logic                 data_wb_rst_i,
  core_wb_data_master_if.master bus
);

  localparam int CW = $clog2(MAX_OUTST + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTST);

  state_t          state_r;
  state_t          state_nxt_s;
  logic [CW-1:0]   count_r;
  logic [CW-1:0]   count_nxt_s;
  logic [CW-1:0]   count_step_s;

  logic            abort_s;
  logic            busy_s;
  logic            stb_s;
  logic            issue_s;
  logic            ack_ok_s;
  logic            err_ok_s;
  logic            err_fire_s;
  logic            tmo_run_s;
  logic            tmo_clear_s;
  logic            tmo_expired_s;

  logic [AW-1:0]   adr_s;
  logic [DW-1:0]   dat_s;
  logic [DW/8-1:0] sel_s;

  assign adr_s = bus.core_adr_i;
  assign dat_s = bus.core_dat_i;
  assign sel_s = bus.core_sel_i;

  // Request/response qualification; bus responses with nothing
  // outstanding are ignored entirely.
  always_comb begin
    abort_s    = (state_r == ABORT);
    busy_s     = (count_r != {CW{1'b0}});
    stb_s      = ~data_wb_rst_i & bus.core_req_i & ~abort_s & (count_r < MAX_CNT);
    issue_s    = stb_s & ~bus.wb_stall_i;
    ack_ok_s   = bus.wb_ack_i & busy_s;
    err_ok_s   = bus.wb_err_i & busy_s;
    err_fire_s = err_ok_s | tmo_expired_s;
    tmo_run_s  = busy_s & ~bus.wb_ack_i & ~bus.wb_err_i;
    tmo_clear_s = ~busy_s | bus.wb_ack_i | bus.wb_err_i;
  end

  // Outstanding count after one issue and/or one ack this cycle.
  always_comb begin
    case ({issue_s, ack_ok_s})
      2'b10:   count_step_s = count_r + CW'(1);
      2'b01:   count_step_s = count_r - CW'(1);
      default: count_step_s = count_r;
    endcase
  end

  // Next-state logic; an error or timeout overrides normal counting.
  always_comb begin
    state_nxt_s = state_r;
    count_nxt_s = count_r;
    if (err_fire_s) begin
      state_nxt_s = ABORT;
      count_nxt_s = {CW{1'b0}};
    end else begin
      case (state_r)
        IDLE, BUSY: begin
          count_nxt_s = count_step_s;
          state_nxt_s = (count_step_s != {CW{1'b0}}) ? BUSY : IDLE;
        end
        ABORT: begin
          count_nxt_s = {CW{1'b0}};
          state_nxt_s = IDLE;
        end
        default: begin
          count_nxt_s = {CW{1'b0}};
          state_nxt_s = IDLE;
        end
      endcase
    end
  end

  // FSM state and outstanding-request count registers.
  always_ff @(posedge data_wb_clk_i or posedge data_wb_rst_i) begin
    if (data_wb_rst_i) begin
      state_r <= IDLE;
      count_r <= {CW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      count_r <= count_nxt_s;
    end
  end

  wb_timeout_ctr #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clk     (data_wb_clk_i),
    .rst     (data_wb_rst_i),
    .run     (tmo_run_s),
    .clear   (tmo_clear_s),
    .expired (tmo_expired_s)
  );

  // Reset gating keeps the bus and response strobes quiet while the
  // core may still be presenting a request.
  assign bus.wb_stb_o      = stb_s;
  assign bus.wb_cyc_o      = ~data_wb_rst_i & ((bus.core_req_i & ~abort_s) | busy_s);
  assign bus.wb_we_o       = bus.core_we_i;
  assign bus.wb_adr_o      = adr_s;
  assign bus.wb_dat_o      = dat_s;
  assign bus.wb_sel_o      = sel_s;
  assign bus.core_stall_o  = bus.core_req_i & ~issue_s;
  assign bus.core_rvalid_o = ~data_wb_rst_i & ack_ok_s;
  assign bus.core_rdata_o  = bus.wb_dat_i;
  assign bus.core_err_o    = ~data_wb_rst_i & err_fire_s;

endmodule

// File: tb/tb_core_wb_data_master.sv
// Directed bench for core_wb_data_master.
// u_dut_a: MAX_OUTST=4, TIMEOUT_CYC=1024. u_dut_b: MAX_OUTST=2, TIMEOUT_CYC=8.
// Inputs change 1ns after the rising edge; outputs are sampled 1ns later.
module tb_core_wb_data_master;
  import core_wb_pkg::*;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  core_wb_data_master_if #(.AW(32), .DW(32)) ifa ();
  core_wb_data_master_if #(.AW(32), .DW(32)) ifb ();

  core_wb_data_master #(.AW(32), .DW(32), .MAX_OUTST(4), .TIMEOUT_CYC(1024)) u_dut_a (
    .data_wb_clk_i (clk),
    .data_wb_rst_i (rst),
    .bus           (ifa)
  );

  core_wb_data_master #(.AW(32), .DW(32), .MAX_OUTST(2), .TIMEOUT_CYC(8)) u_dut_b (
    .data_wb_clk_i (clk),
    .data_wb_rst_i (rst),
    .bus           (ifb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ifa.core_req_i = 1'b0; ifa.core_we_i = 1'b0; ifa.core_adr_i = 32'h0;
    ifa.core_dat_i = 32'h0; ifa.core_sel_i = 4'h0; ifa.wb_stall_i = 1'b0;
    ifa.wb_ack_i = 1'b0; ifa.wb_err_i = 1'b0; ifa.wb_dat_i = 32'h0;
    ifb.core_req_i = 1'b0; ifb.core_we_i = 1'b0; ifb.core_adr_i = 32'h0;
    ifb.core_dat_i = 32'h0; ifb.core_sel_i = 4'h0; ifb.wb_stall_i = 1'b0;
    ifb.wb_ack_i = 1'b0; ifb.wb_err_i = 1'b0; ifb.wb_dat_i = 32'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    ifa.core_req_i = 1'b1; ifa.wb_ack_i = 1'b1; ifa.wb_err_i = 1'b1;
    #1;
    checks++; if (ifa.wb_cyc_o !== 1'b0) begin errors++; $display("FAIL reset_cyc: got %b want 0", ifa.wb_cyc_o); end
    checks++; if (ifa.wb_stb_o !== 1'b0) begin errors++; $display("FAIL reset_stb: got %b want 0", ifa.wb_stb_o); end
    checks++; if (ifa.core_rvalid_o !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b want 0", ifa.core_rvalid_o); end
    checks++; if (ifa.core_err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", ifa.core_err_o); end
    tick();
    clear_inputs();
    rst = 1'b0;
    #1;
    checks++; if (ifa.wb_cyc_o !== 1'b0) begin errors++; $display("FAIL idle_cyc: got %b want 0", ifa.wb_cyc_o); end
    tick();
    ifa.wb_ack_i = 1'b1; ifa.wb_err_i = 1'b1;
    #1;
    checks++; if (ifa.core_rvalid_o !== 1'b0) begin errors++; $display("FAIL idle_ack_ignored: got %b want 0", ifa.core_rvalid_o); end
    checks++; if (ifa.core_err_o !== 1'b0) begin errors++; $display("FAIL idle_err_ignored: got %b want 0", ifa.core_err_o); end
    tick();
    clear_inputs();
    #1;
    checks++; if (ifa.wb_cyc_o !== 1'b0) begin errors++; $display("FAIL idle_after_ignored: got %b want 0", ifa.wb_cyc_o); end
  endtask

  // Four reads issued back to back, each acked two cycles after issue.
  task automatic test_back_to_back();
    logic e_rv, e_cyc, e_stb;
    logic [31:0] e_dat;
    for (int k = 0; k < 7; k++) begin
      tick();
      ifa.core_req_i = (k < 4);
      ifa.core_we_i  = 1'b0;
      ifa.core_adr_i = 32'h0000_0100 + 32'(k * 4);
      ifa.wb_ack_i   = (k >= 2 && k <= 5);
      ifa.wb_dat_i   = 32'hD000_0000 + 32'(k);
      #1;
      e_stb = (k < 4);
      e_rv  = (k >= 2 && k <= 5);
      e_cyc = (k <= 5);
      e_dat = 32'hD000_0000 + 32'(k);
      checks++; if (ifa.wb_stb_o !== e_stb) begin errors++; $display("FAIL b2b_stb k=%0d: got %b want %b", k, ifa.wb_stb_o, e_stb); end
      checks++; if (ifa.core_stall_o !== 1'b0) begin errors++; $display("FAIL b2b_stall k=%0d: got %b want 0", k, ifa.core_stall_o); end
      checks++; if (ifa.core_rvalid_o !== e_rv) begin errors++; $display("FAIL b2b_rvalid k=%0d: got %b want %b", k, ifa.core_rvalid_o, e_rv); end
      checks++; if (ifa.wb_cyc_o !== e_cyc) begin errors++; $display("FAIL b2b_cyc k=%0d: got %b want %b", k, ifa.wb_cyc_o, e_cyc); end
      if (e_rv) begin
        checks++; if (ifa.core_rdata_o !== e_dat) begin errors++; $display("FAIL b2b_rdata k=%0d: got %h want %h", k, ifa.core_rdata_o, e_dat); end
      end
    end
    clear_inputs();
  endtask

  // MAX_OUTST=2: third held request stalls until the first ack drains one.
  task automatic test_max_outst();
    logic [8:0] e_stb, e_stall, e_cyc, e_rv, ack_v;
    e_stb   = 9'b0_0010_0011;
    e_stall = 9'b0_0001_1100;
    e_cyc   = 9'b0_1111_1111;
    e_rv    = 9'b0_1101_0000;
    ack_v   = 9'b0_1101_0000;
    for (int k = 0; k < 9; k++) begin
      tick();
      ifb.core_req_i = (k <= 5);
      ifb.core_adr_i = 32'h0000_0200 + 32'(k);
      ifb.wb_ack_i   = ack_v[k];
      ifb.wb_dat_i   = 32'h0000_5A00 + 32'(k);
      #1;
      checks++; if (ifb.wb_stb_o !== e_stb[k]) begin errors++; $display("FAIL outst_stb k=%0d: got %b want %b", k, ifb.wb_stb_o, e_stb[k]); end
      checks++; if (ifb.core_stall_o !== e_stall[k]) begin errors++; $display("FAIL outst_stall k=%0d: got %b want %b", k, ifb.core_stall_o, e_stall[k]); end
      checks++; if (ifb.wb_cyc_o !== e_cyc[k]) begin errors++; $display("FAIL outst_cyc k=%0d: got %b want %b", k, ifb.wb_cyc_o, e_cyc[k]); end
      checks++; if (ifb.core_rvalid_o !== e_rv[k]) begin errors++; $display("FAIL outst_rvalid k=%0d: got %b want %b", k, ifb.core_rvalid_o, e_rv[k]); end
      checks++; if (ifb.core_err_o !== 1'b0) begin errors++; $display("FAIL outst_err k=%0d: got %b want 0", k, ifb.core_err_o); end
    end
    clear_inputs();
  endtask

  // Write held against wb_stall_i for five cycles, issued on the sixth.
  task automatic test_stall_write();
    logic e_stb, e_stall, e_cyc, e_rv;
    for (int k = 0; k < 9; k++) begin
      tick();
      ifa.core_req_i = (k <= 5);
      ifa.core_we_i  = 1'b1;
      ifa.core_adr_i = 32'h0000_2040;
      ifa.core_dat_i = 32'hCAFE_F00D;
      ifa.core_sel_i = 4'b0110;
      ifa.wb_stall_i = (k <= 4);
      ifa.wb_ack_i   = (k == 7);
      #1;
      e_stb   = (k <= 5);
      e_stall = (k <= 4);
      e_cyc   = (k <= 7);
      e_rv    = (k == 7);
      checks++; if (ifa.wb_stb_o !== e_stb) begin errors++; $display("FAIL stw_stb k=%0d: got %b want %b", k, ifa.wb_stb_o, e_stb); end
      checks++; if (ifa.core_stall_o !== e_stall) begin errors++; $display("FAIL stw_stall k=%0d: got %b want %b", k, ifa.core_stall_o, e_stall); end
      checks++; if (ifa.wb_cyc_o !== e_cyc) begin errors++; $display("FAIL stw_cyc k=%0d: got %b want %b", k, ifa.wb_cyc_o, e_cyc); end
      checks++; if (ifa.core_rvalid_o !== e_rv) begin errors++; $display("FAIL stw_rvalid k=%0d: got %b want %b", k, ifa.core_rvalid_o, e_rv); end
      if (k == 0) begin
        checks++; if (ifa.wb_we_o !== 1'b1) begin errors++; $display("FAIL stw_we: got %b want 1", ifa.wb_we_o); end
        checks++; if (ifa.wb_adr_o !== 32'h0000_2040) begin errors++; $display("FAIL stw_adr: got %h want 00002040", ifa.wb_adr_o); end
        checks++; if (ifa.wb_dat_o !== 32'hCAFE_F00D) begin errors++; $display("FAIL stw_dat: got %h want cafef00d", ifa.wb_dat_o); end
        checks++; if (ifa.wb_sel_o !== 4'b0110) begin errors++; $display("FAIL stw_sel: got %b want 0110", ifa.wb_sel_o); end
      end
    end
    clear_inputs();
  endtask

  // Error on the second of three outstanding reads, then a late ack.
  task automatic test_err_abort();
    logic [9:0] req_v, ack_v, err_v, e_stb, e_stall, e_cyc, e_rv, e_err;
    req_v   = 10'b00_1010_0111;
    ack_v   = 10'b01_0100_1000;
    err_v   = 10'b00_0001_0000;
    e_stb   = 10'b00_1000_0111;
    e_stall = 10'b00_0010_0000;
    e_cyc   = 10'b01_1001_1111;
    e_rv    = 10'b01_0000_1000;
    e_err   = 10'b00_0001_0000;
    for (int k = 0; k < 10; k++) begin
      tick();
      ifa.core_req_i = req_v[k];
      ifa.core_adr_i = 32'h0000_3000 + 32'(k * 4);
      ifa.wb_ack_i   = ack_v[k];
      ifa.wb_err_i   = err_v[k];
      ifa.wb_dat_i   = 32'h0000_E000 + 32'(k);
      #1;
      checks++; if (ifa.wb_stb_o !== e_stb[k]) begin errors++; $display("FAIL err_stb k=%0d: got %b want %b", k, ifa.wb_stb_o, e_stb[k]); end
      checks++; if (ifa.core_stall_o !== e_stall[k]) begin errors++; $display("FAIL err_stall k=%0d: got %b want %b", k, ifa.core_stall_o, e_stall[k]); end
      checks++; if (ifa.wb_cyc_o !== e_cyc[k]) begin errors++; $display("FAIL err_cyc k=%0d: got %b want %b", k, ifa.wb_cyc_o, e_cyc[k]); end
      checks++; if (ifa.core_rvalid_o !== e_rv[k]) begin errors++; $display("FAIL err_rvalid k=%0d: got %b want %b", k, ifa.core_rvalid_o, e_rv[k]); end
      checks++; if (ifa.core_err_o !== e_err[k]) begin errors++; $display("FAIL err_pulse k=%0d: got %b want %b", k, ifa.core_err_o, e_err[k]); end
    end
    clear_inputs();
  endtask

  // TIMEOUT_CYC=8: an unanswered read errors on its 8th waiting cycle.
  task automatic test_timeout();
    logic [12:0] req_v, ack_v, e_cyc, e_err, e_rv;
    req_v = 13'b0_0100_0000_0001;
    ack_v = 13'b0_1000_0000_0000;
    e_cyc = 13'b0_1101_1111_1111;
    e_err = 13'b0_0001_0000_0000;
    e_rv  = 13'b0_1000_0000_0000;
    for (int k = 0; k < 13; k++) begin
      tick();
      ifb.core_req_i = req_v[k];
      ifb.core_adr_i = 32'h0000_4000;
      ifb.wb_ack_i   = ack_v[k];
      ifb.wb_dat_i   = 32'h0000_7700 + 32'(k);
      #1;
      checks++; if (ifb.wb_cyc_o !== e_cyc[k]) begin errors++; $display("FAIL tmo_cyc k=%0d: got %b want %b", k, ifb.wb_cyc_o, e_cyc[k]); end
      checks++; if (ifb.core_err_o !== e_err[k]) begin errors++; $display("FAIL tmo_err k=%0d: got %b want %b", k, ifb.core_err_o, e_err[k]); end
      checks++; if (ifb.core_rvalid_o !== e_rv[k]) begin errors++; $display("FAIL tmo_rvalid k=%0d: got %b want %b", k, ifb.core_rvalid_o, e_rv[k]); end
    end
    clear_inputs();
  endtask

  // Reset with two reads outstanding; later acks must be ignored.
  task automatic test_reset_mid();
    for (int k = 0; k < 2; k++) begin
      tick();
      ifa.core_req_i = 1'b1;
      ifa.core_adr_i = 32'h0000_5000 + 32'(k * 4);
    end
    tick();
    ifa.core_req_i = 1'b0;
    #1;
    checks++; if (ifa.wb_cyc_o !== 1'b1) begin errors++; $display("FAIL rstmid_pre_cyc: got %b want 1", ifa.wb_cyc_o); end
    rst = 1'b1;
    ifa.core_req_i = 1'b1;
    #1;
    checks++; if (ifa.wb_cyc_o !== 1'b0) begin errors++; $display("FAIL rstmid_cyc: got %b want 0", ifa.wb_cyc_o); end
    checks++; if (ifa.wb_stb_o !== 1'b0) begin errors++; $display("FAIL rstmid_stb: got %b want 0", ifa.wb_stb_o); end
    tick();
    rst = 1'b0;
    ifa.core_req_i = 1'b0;
    ifa.wb_ack_i = 1'b1;
    #1;
    checks++; if (ifa.core_rvalid_o !== 1'b0) begin errors++; $display("FAIL rstmid_rvalid0: got %b want 0", ifa.core_rvalid_o); end
    checks++; if (ifa.wb_cyc_o !== 1'b0) begin errors++; $display("FAIL rstmid_post_cyc: got %b want 0", ifa.wb_cyc_o); end
    tick();
    #1;
    checks++; if (ifa.core_rvalid_o !== 1'b0) begin errors++; $display("FAIL rstmid_rvalid1: got %b want 0", ifa.core_rvalid_o); end
    clear_inputs();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_back_to_back();
    test_max_outst();
    test_stall_write();
    test_err_abort();
    test_timeout();
    test_reset_mid();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
